// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative vectoring-mode CORDIC: (x, y) -> magnitude and whole-degree angle
// Define CORDIC_GAIN_COMP_EN to add a one-cycle GAIN step that scales the magnitude by ~0.6073.
module cordic_vector #(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+1:0]        mag_out,
    output logic signed [9:0]       angle_out
);
    localparam int XW = WIDTH + 2;
    localparam int KW = ($clog2(ITERATIONS + 1) < 3) ? 3 : $clog2(ITERATIONS + 1);
    localparam logic signed [9:0] ATAN [0:7] = '{10'sd45, 10'sd26, 10'sd14, 10'sd7,
                                                 10'sd4, 10'sd2, 10'sd1, 10'sd0};

    typedef enum logic [1:0] {IDLE, RUN, GAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [9:0]     z_q, z_d;
    logic                  zero_q, zero_d;
    logic [XW-1:0]         mag_q, mag_d;
    logic signed [9:0]     angle_q, angle_d;
    logic                  out_valid_q, out_valid_d;

    logic signed [XW-1:0]  x_ext, y_ext, x_sh, y_sh;
    logic signed [9:0]     atan_k, z_wrap;
    logic                  last_iter;

    always_comb begin
        x_ext     = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext     = {{2{y_in[WIDTH-1]}}, y_in};
        x_sh      = x_q >>> k_q;
        y_sh      = y_q >>> k_q;
        atan_k    = (k_q < KW'(7)) ? ATAN[k_q[2:0]] : 10'sd0;
        last_iter = (k_q == KW'(ITERATIONS - 1));
        if (z_q > 10'sd180)
            z_wrap = z_q - 10'sd360;
        else if (z_q <= -10'sd180)
            z_wrap = z_q + 10'sd360;
        else
            z_wrap = z_q;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        mag_d       = mag_q;
        angle_d     = angle_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                k_d = '0;
                if (in_valid) begin
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = RUN;
                    // Fold the left half-plane into the right so the iterations converge.
                    if (!x_in[WIDTH-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = 10'sd0;
                    end else if (!y_in[WIDTH-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = 10'sd90;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -10'sd90;
                    end
                end
            end
            RUN: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_k;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_k;
                end
                k_d = k_q + KW'(1);
                if (last_iter) begin
                    k_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = GAIN;
`else
                    state_d = DONE;
`endif
                end
            end
            GAIN: begin
                x_d     = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9) - (x_q >>> 13);
                state_d = DONE;
            end
            DONE: begin
                // First DONE cycle registers the result; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    mag_d       = zero_q ? '0 : x_q;
                    angle_d     = zero_q ? 10'sd0 : z_wrap;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign mag_out   = mag_q;
    assign angle_out = angle_q;
endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - table-driven, scoreboarded bench for cordic_vector
module tb_cordic_vector;
    localparam int WIDTH = 16;
    localparam int ITER  = 20;
`ifdef CORDIC_GAIN_COMP_EN
    localparam real GAIN = 1.0;
    localparam int  LAT  = ITER + 2;
`else
    localparam real GAIN = 1.64676;
    localparam int  LAT  = ITER + 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [WIDTH+1:0]        mag_out;
    logic signed [9:0]       angle_out;

    cordic_vector #(.WIDTH(WIDTH), .ITERATIONS(ITER)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .mag_out(mag_out), .angle_out(angle_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int exp_ang;
        int ang_tol;
    } vec_t;

    typedef struct {
        real mag;
        real mag_tol;
        int  ang;
        int  ang_tol;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int ang_err(input int got, input int want);
        int d;
        d = got - want;
        while (d > 180) d -= 360;
        while (d <= -180) d += 360;
        return (d < 0) ? -d : d;
    endfunction

    task automatic start(input int x, input int y, input int exp_ang, input int tol);
        exp_t e;
        bit   acc;
        int   n;
        e.mag     = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GAIN;
        e.mag_tol = (x == 0 && y == 0) ? 0.0 : e.mag * 0.01 + 2.0;
        e.ang     = exp_ang;
        e.ang_tol = tol;
        x_in      = 16'(x);
        y_in      = 16'(y);
        in_valid  = 1'b1;
        acc       = 1'b0;
        n         = 0;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 1'b0, n, 50);
        else sb.push_back(e);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic finish_xfer(input string name);
        exp_t e;
        int   m;
        if (sb.size() == 0) begin
            chk({name, "_scoreboard_empty"}, 1'b0, 0, 1);
        end else begin
            e = sb.pop_front();
            m = int'(mag_out);
            chk({name, "_mag"}, ($itor(m) >= e.mag - e.mag_tol) && ($itor(m) <= e.mag + e.mag_tol),
                m, $rtoi(e.mag));
            chk({name, "_angle"}, ang_err(int'(angle_out), e.ang) <= e.ang_tol,
                int'(angle_out), e.ang);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_in_ready_after_xfer"}, in_ready && !out_valid, int'(in_ready), 1);
    endtask

    vec_t vecs[7];
    int   cyc;
    int   m0, a0, seen;

    initial begin
        vecs[0] = '{1000, 0, 0, 3};
        vecs[1] = '{0, 1000, 90, 3};
        vecs[2] = '{-1000, 0, 180, 3};
        vecs[3] = '{0, -1000, -90, 3};
        vecs[4] = '{-707, -707, -135, 3};
        vecs[5] = '{-32768, -32768, -135, 3};
        vecs[6] = '{0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        chk("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("reset_mag", mag_out == '0, int'(mag_out), 0);
        chk("reset_angle", angle_out == '0, int'(angle_out), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            start(vecs[i].x, vecs[i].y, vecs[i].exp_ang, vecs[i].ang_tol);
            wait_valid(cyc);
            chk($sformatf("vec%0d_latency", i), cyc == LAT, cyc, LAT);
            finish_xfer($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and the engine must refuse new work.
        start(-500, 800, 122, 3);
        wait_valid(cyc);
        chk("bp_latency", cyc == LAT, cyc, LAT);
        m0 = int'(mag_out);
        a0 = int'(angle_out);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x_in     = 16'($urandom_range(0, 2000));
            y_in     = 16'($urandom_range(0, 2000));
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", i),
                out_valid && !in_ready && int'(mag_out) == m0 && int'(angle_out) == a0,
                int'(mag_out), m0);
        end
        in_valid = 1'b0;
        finish_xfer("bp");
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen++;
        end
        chk("bp_pulses_ignored", seen == 0, seen, 0);

        // Abort with rst once k has reached 5.
        start(1000, 1000, 45, 3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("abort_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen == 0, seen, 0);
        chk("abort_idle_ready", in_ready == 1'b1, int'(in_ready), 1);

        // Tiny operands: shift truncation adds about a degree beyond the table error.
        start(3, 4, 53, 4);
        wait_valid(cyc);
        chk("small_latency", cyc == LAT, cyc, LAT);
        finish_xfer("small");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
